// File: rtl/uart_calc_printer_if.sv
// Byte-level link between the calculator/printer and its UART: receive strobe,
// transmit strobe with busy back-pressure, plus the block's status outputs.
interface uart_calc_printer_if;
  logic [7:0] rx_data;
  logic       new_rx_data;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy;
  logic       busy;
  logic [7:0] ledout;

  modport slave (
    input  rx_data, new_rx_data, tx_busy,
    output tx_data, new_tx_data, busy, ledout
  );

  modport master (
    output rx_data, new_rx_data, tx_busy,
    input  tx_data, new_tx_data, busy, ledout
  );
endinterface

// File: rtl/uart_calc_printer.sv
// UART command calculator: collects an opcode plus N_BYTES little-endian operand
// bytes, computes a signed result and prints it in decimal followed by CR LF.
module uart_calc_printer #(
  parameter int N_BYTES        = 4,
  parameter int MULT           = 2,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                clk,
  input  logic                rst,
  uart_calc_printer_if.slave  bus_io
);

  localparam int W    = 8 * N_BYTES;
  // Decimal digits needed for 2^(W-1): floor(W*log10(2)) + 1, log10(2) ~ 77/256.
  localparam int NDIG = (W * 77) / 256 + 1;
  localparam int KW   = $clog2(N_BYTES + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW   = $clog2(W + 1);
  localparam int DW   = $clog2(NDIG + 1);

  localparam logic [KW-1:0]        LAST_BYTE = KW'(N_BYTES - 1);
  localparam logic [TW-1:0]        TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0]        DIV_STEPS = SW'(W);
  localparam logic signed [W-1:0]  MULT_S    = W'(MULT);

  localparam logic [7:0] OP_H = 8'h68;
  localparam logic [7:0] OP_S = 8'h73;
  localparam logic [7:0] OP_N = 8'h6E;

  typedef enum logic [2:0] {IDLE, COLLECT, COMPUTE, ABS, CONVERT, PRINT} state_t;

  function automatic logic [W-1:0] f_abs(input logic signed [W-1:0] v);
    return v[W-1] ? unsigned'(-v) : unsigned'(v);
  endfunction

  state_t               state_q;
  logic [7:0]           opc_q;
  logic [W-1:0]         op_q;
  logic [KW-1:0]        cnt_q;
  logic [TW-1:0]        to_q;
  logic signed [W-1:0]  r_q;
  logic                 neg_q;
  logic [W-1:0]         dq_q;
  logic [3:0]           rem_q;
  logic [SW-1:0]        step_q;
  logic [3:0]           dig_q [NDIG];
  logic [DW-1:0]        ndig_q;
  logic [DW-1:0]        dig_idx_q;
  logic [1:0]           ph_q;
  logic [7:0]           tx_data_q;
  logic                 new_tx_q;
  logic                 busy_q;
  logic [7:0]           led_q;

  logic signed [W-1:0]  op_s;
  logic signed [W-1:0]  r_d;
  logic [W-1:0]         m_d;
  logic [4:0]           rem_sh;
  logic [3:0]           rem_d;
  logic [W-1:0]         dq_d;
  logic [7:0]           char_d;

  assign op_s   = signed'(op_q);
  assign m_d    = f_abs(r_q);
  assign rem_sh = {rem_q, dq_q[W-1]};

  always_comb begin
    r_d = -op_s;
    case (opc_q)
      OP_H:    r_d = op_s * MULT_S;
      OP_S:    r_d = op_s * op_s;
      default: r_d = -op_s;
    endcase
  end

  // One restoring step: dividend bits shift out the top, quotient bits shift in below.
  always_comb begin
    rem_d = rem_sh[3:0];
    dq_d  = {dq_q[W-2:0], 1'b0};
    if (rem_sh >= 5'd10) begin
      rem_d = 4'(rem_sh - 5'd10);
      dq_d  = {dq_q[W-2:0], 1'b1};
    end
  end

  always_comb begin
    char_d = 8'h0A;
    case (ph_q)
      2'd0:    char_d = 8'h2D;
      2'd1:    char_d = 8'h30 + {4'h0, dig_q[dig_idx_q]};
      2'd2:    char_d = 8'h0D;
      default: char_d = 8'h0A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      new_tx_q  <= 1'b0;
      busy_q    <= 1'b0;
      tx_data_q <= 8'h00;
      led_q     <= 8'h00;
      cnt_q     <= '0;
      to_q      <= '0;
      ndig_q    <= '0;
    end else begin
      new_tx_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus_io.new_rx_data &&
              (bus_io.rx_data == OP_H || bus_io.rx_data == OP_S || bus_io.rx_data == OP_N)) begin
            opc_q   <= bus_io.rx_data;
            cnt_q   <= '0;
            to_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          // A byte arriving on the timeout cycle wins over the timeout.
          if (bus_io.new_rx_data) begin
            op_q[8*cnt_q +: 8] <= bus_io.rx_data;
            cnt_q              <= cnt_q + KW'(1);
            to_q               <= '0;
            if (cnt_q == LAST_BYTE) state_q <= COMPUTE;
          end else if (to_q == TO_LAST) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            to_q <= to_q + TW'(1);
          end
        end
        COMPUTE: begin
          r_q     <= r_d;
          state_q <= ABS;
        end
        ABS: begin
          neg_q   <= r_q[W-1];
          dq_q    <= m_d;
          led_q   <= m_d[7:0];
          rem_q   <= 4'h0;
          step_q  <= '0;
          ndig_q  <= '0;
          state_q <= CONVERT;
        end
        CONVERT: begin
          if (step_q != DIV_STEPS) begin
            rem_q  <= rem_d;
            dq_q   <= dq_d;
            step_q <= step_q + SW'(1);
          end else begin
            // dq_q now holds the quotient, which becomes the next dividend.
            dig_q[ndig_q] <= rem_q;
            ndig_q        <= ndig_q + DW'(1);
            rem_q         <= 4'h0;
            step_q        <= '0;
            if (dq_q == '0) begin
              ph_q      <= neg_q ? 2'd0 : 2'd1;
              dig_idx_q <= ndig_q;
              state_q   <= PRINT;
            end
          end
        end
        PRINT: begin
          // The cycle after a strobe is a forced gap; tx_busy is not looked at then.
          if (new_tx_q) begin
            if (tx_data_q == 8'h0A) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else if (!bus_io.tx_busy) begin
            tx_data_q <= char_d;
            new_tx_q  <= 1'b1;
            case (ph_q)
              2'd0: ph_q <= 2'd1;
              2'd1: begin
                if (dig_idx_q == '0) ph_q <= 2'd2;
                else dig_idx_q <= dig_idx_q - DW'(1);
              end
              2'd2: ph_q <= 2'd3;
              default: ph_q <= 2'd3;
            endcase
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_io.tx_data     = tx_data_q;
  assign bus_io.new_tx_data = new_tx_q;
  assign bus_io.busy        = busy_q;
  assign bus_io.ledout      = led_q;

endmodule

// File: tb/tb_uart_calc_printer.sv
// Scoreboard bench for uart_calc_printer: a reference model queues the expected
// printed characters per command and a monitor pops them as the DUT transmits.
module tb_uart_calc_printer;

  localparam int MULT = 2;
  localparam int TO   = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_calc_printer_if bif ();

  uart_calc_printer #(
    .N_BYTES(4), .MULT(MULT), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .bus_io(bif)
  );

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_led = 8'h00;
  bit         busy_mode = 1'b0;
  int         n_strobes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: plain signed arithmetic and decimal formatting.
  task automatic push_expected(input logic [7:0] opc, input logic [31:0] op);
    longint a, p, m;
    int     r;
    string  s;
    a = longint'(signed'(op));
    case (opc)
      8'h68:   p = a * MULT;
      8'h73:   p = a * a;
      default: p = -a;
    endcase
    r = int'(p);
    m = (r < 0) ? -longint'(r) : longint'(r);
    s = $sformatf("%0d", m);
    if (r < 0) exp_q.push_back(8'h2D);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    exp_led = m[7:0];
  endtask

  // Monitor: checks every transmit strobe against the scoreboard, models tx_busy.
  initial begin
    int         busy_cnt;
    bit         last_strobe;
    logic [7:0] last_tx;
    logic [7:0] e;
    busy_cnt    = 0;
    last_strobe = 1'b0;
    last_tx     = 8'h00;
    bif.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_tx     = 8'h00;
        last_strobe = 1'b0;
      end else begin
        if (bif.new_tx_data) begin
          n_strobes++;
          chk("strobe_while_tx_busy", bif.tx_busy, 1'b0);
          chk("strobe_without_gap", last_strobe, 1'b0);
          if (exp_q.size() == 0) begin
            chk("unexpected_strobe", bif.tx_data, 8'h00);
            if (bif.tx_data == 8'h00) chk("unexpected_strobe_count", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk("tx_char", bif.tx_data, e);
          end
          last_tx = bif.tx_data;
          if (busy_mode) busy_cnt = 20;
        end else begin
          chk("tx_data_stable", bif.tx_data, last_tx);
        end
        last_strobe = bif.new_tx_data;
      end
      bif.tx_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    bif.rx_data     = b;
    bif.new_rx_data = 1'b1;
    @(negedge clk);
    bif.new_rx_data = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bif.busy) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_finished"}, (t < 20000), 1'b1);
    chk({name, "_chars_left"}, exp_q.size(), 0);
    chk({name, "_ledout"}, bif.ledout, exp_led);
    chk({name, "_busy_after"}, bif.busy, 1'b0);
  endtask

  task automatic send_cmd(input string name, input logic [7:0] opc, input logic [31:0] op,
                          input int maxgap, input bit junk_after);
    push_expected(opc, op);
    send_byte(opc, $urandom_range(0, maxgap));
    for (int i = 0; i < 4; i++) send_byte(op[8*i +: 8], $urandom_range(0, maxgap));
    if (junk_after) send_byte(8'h68, 2);
    wait_done(name);
  endtask

  function automatic logic [7:0] pick_opc(input int k);
    case (k)
      0:       return 8'h68;
      1:       return 8'h73;
      default: return 8'h6E;
    endcase
  endfunction

  initial begin
    logic [7:0]  b;
    logic [31:0] op;
    int          t;
    int          base;
    rst             = 1'b1;
    bif.rx_data     = 8'h00;
    bif.new_rx_data = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx_data", bif.tx_data, 8'h00);
    chk("reset_new_tx", bif.new_tx_data, 1'b0);
    chk("reset_busy", bif.busy, 1'b0);
    chk("reset_ledout", bif.ledout, 8'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    send_cmd("h_pos5", 8'h68, 32'h0000_0005, 0, 1'b0);
    send_cmd("h_neg5", 8'h68, 32'hFFFF_FFFB, 0, 1'b0);
    send_cmd("s_3", 8'h73, 32'h0000_0003, 0, 1'b0);
    send_cmd("n_min", 8'h6E, 32'h8000_0000, 0, 1'b0);
    send_cmd("h_zero", 8'h68, 32'h0000_0000, 0, 1'b0);
    send_cmd("s_data_opcode_bytes", 8'h73, 32'h6E73_6868, 1, 1'b1);

    // Partial command then silence: must drop back to IDLE without printing.
    send_byte(8'h68, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    chk("collect_busy", bif.busy, 1'b1);
    repeat (TO + 20) @(negedge clk);
    chk("timeout_idle", bif.busy, 1'b0);
    send_cmd("after_timeout", 8'h68, 32'h0000_0005, 0, 1'b0);

    busy_mode = 1'b1;
    send_cmd("busy_h_neg5", 8'h68, 32'hFFFF_FFFB, 0, 1'b0);
    send_cmd("busy_n_max", 8'h6E, 32'h7FFF_FFFF, 2, 1'b1);

    // Reset right after the first printed character.
    push_expected(8'h68, 32'h1234_5678);
    base = n_strobes;
    send_byte(8'h68, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    t = 0;
    while (n_strobes == base && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("first_char_seen", (n_strobes > base), 1'b1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rst_new_tx", bif.new_tx_data, 1'b0);
    chk("rst_busy", bif.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_led = 8'h00;
    repeat (100) @(negedge clk);
    chk("post_rst_busy", bif.busy, 1'b0);
    chk("post_rst_ledout", bif.ledout, 8'h00);
    chk("post_rst_no_strobes", n_strobes, base + 1);
    send_cmd("after_reset", 8'h68, 32'h0000_0005, 0, 1'b0);

    busy_mode = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        do b = 8'($urandom_range(0, 255));
        while (b == 8'h68 || b == 8'h73 || b == 8'h6E);
        send_byte(b, 1);
        chk("junk_ignored", bif.busy, 1'b0);
      end
      case ($urandom_range(0, 5))
        0:       op = 32'h7FFF_FFFF;
        1:       op = 32'h8000_0000;
        2:       op = 32'hFFFF_FFFF;
        default: op = $urandom();
      endcase
      if (i == 8) busy_mode = 1'b1;
      send_cmd("random", pick_opc($urandom_range(0, 2)), op, 3, bit'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
